// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, register-file geometry and the
// write-back source encoding used by the MEM/WB stage.
package cpu_pkg;

  localparam int DATA_W = 16;           // register/data width
  localparam int ADDR_W = 3;            // register address width
  localparam int REG_N  = 1 << ADDR_W;  // number of architectural registers
  localparam int CNT_W  = 2;            // per-register in-flight write counter width

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_MEM = 2'd1,
    WB_SRC_IN  = 2'd2,
    WB_SRC_BAD = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one saturating counter per register counting
// writes that have been issued by decode but have not yet landed.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   inc_en/inc_addr issue of a write to register inc_addr (counter +1)
//   dec_en/dec_addr retirement of a write to register dec_addr (counter -1)
//   pending         bit r set while register r has at least one write in flight
//   err_overflow    sticky: issue to a register whose counter is already full
//   err_underflow   sticky: retire to a register whose counter is already zero
module wb_scoreboard
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_en,
  input  logic [ADDR_W-1:0] inc_addr,
  input  logic              dec_en,
  input  logic [ADDR_W-1:0] dec_addr,
  output logic [REG_N-1:0]  pending,
  output logic              err_overflow,
  output logic              err_underflow
);

  logic [CNT_W-1:0] cnt_q [REG_N];
  logic [CNT_W-1:0] cnt_d [REG_N];
  logic [REG_N-1:0] inc_hit;
  logic [REG_N-1:0] dec_hit;
  logic             ovf_hit;
  logic             unf_hit;

  // One-hot decode of the issue and retire targets.
  assign inc_hit = inc_en ? (REG_N'(1) << inc_addr) : '0;
  assign dec_hit = dec_en ? (REG_N'(1) << dec_addr) : '0;

  // NOTE: every variable driven here gets a default before the loop/case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    for (int r = 0; r < REG_N; r++) begin
      cnt_d[r] = cnt_q[r];
      // Issue and retire on the same register in one cycle cancel out.
      case ({inc_hit[r], dec_hit[r]})
        2'b10: begin
          if (cnt_q[r] == CNT_MAX) ovf_hit  = 1'b1;
          else                     cnt_d[r] = cnt_q[r] + CNT_W'(1);
        end
        2'b01: begin
          if (cnt_q[r] == '0) unf_hit  = 1'b1;
          else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // NOTE: the counters are control state, not data storage, so they are all
  // cleared on reset; a stale count would leave a permanently pending register.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < REG_N; r++) cnt_q[r] <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      err_overflow  <= err_overflow  | ovf_hit;
      err_underflow <= err_underflow | unf_hit;
    end
  end

  always_comb begin
    pending = '0;
    for (int r = 0; r < REG_N; r++) pending[r] = (cnt_q[r] != '0);
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Write side of the 8x16 register file: MEM/WB pipeline register, write-data
// source mux and register-file write-port driver, plus the pending-write
// scoreboard that decode marks at issue and this unit clears at retire.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   issue_valid/issue_dst       decode issues a write to issue_dst
//   wb_valid/wb_dst/wb_src      write-back request from MEM (src: ALU/MEM/IN/illegal)
//   alu_result/mem_data/in_data candidate write data
//   rf_we/rf_waddr/rf_wdata     registered register-file write port
//   pending                     per-register outstanding-write flags
//   err_overflow/err_underflow  sticky scoreboard saturation errors
//   err_src                     sticky: write-back request with the illegal source
module reg_writeback_unit
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dst,
  input  logic [1:0]        wb_src,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] in_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [REG_N-1:0]  pending,
  output logic              err_overflow,
  output logic              err_underflow,
  output logic              err_src
);

  logic [DATA_W-1:0] wdata_sel;
  logic              src_bad;
  logic              wb_legal;
  logic              ret_valid;  // a sampled request retires on the coming edge
  logic [ADDR_W-1:0] ret_addr;

  assign src_bad  = (wb_src == WB_SRC_BAD);
  assign wb_legal = wb_valid && !src_bad;

  always_comb begin
    wdata_sel = '0;
    case (wb_src)
      WB_SRC_ALU: wdata_sel = alu_result;
      WB_SRC_MEM: wdata_sel = mem_data;
      WB_SRC_IN:  wdata_sel = in_data;
      default:    wdata_sel = '0;
    endcase
  end

  // MEM/WB register. The retire address is tracked separately from rf_waddr
  // because an illegal-source request must still retire even though it never
  // updates the write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      ret_valid <= 1'b0;
      ret_addr  <= '0;
      err_src   <= 1'b0;
    end else begin
      rf_we     <= wb_legal;
      if (wb_legal) begin
        rf_waddr <= wb_dst;
        rf_wdata <= wdata_sel;
      end
      ret_valid <= wb_valid;
      ret_addr  <= wb_dst;
      err_src   <= err_src | (wb_valid && src_bad);
    end
  end

  wb_scoreboard u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .inc_en        (issue_valid),
    .inc_addr      (issue_dst),
    .dec_en        (ret_valid),
    .dec_addr      (ret_addr),
    .pending       (pending),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Bench for reg_writeback_unit: reset with random inputs, a directed vector
// table covering the write path, scoreboard corners and reset-in-flight, then
// randomized traffic compared against a queue-based behavioural model.
module tb_reg_writeback_unit;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_dst;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_dst;
  logic [1:0]        wb_src;
  logic [DATA_W-1:0] alu_result, mem_data, in_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [REG_N-1:0]  pending;
  logic              err_overflow, err_underflow, err_src;

  int errors = 0;
  int checks = 0;

  reg_writeback_unit dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_dst     (issue_dst),
    .wb_valid      (wb_valid),
    .wb_dst        (wb_dst),
    .wb_src        (wb_src),
    .alu_result    (alu_result),
    .mem_data      (mem_data),
    .in_data       (in_data),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .pending       (pending),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_src       (err_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [2:0]  idst;
    logic        wv;
    logic [2:0]  wdst;
    logic [1:0]  src;
    logic [15:0] alu;
    logic [15:0] mem;
    logic [15:0] inp;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [7:0]  pend;
    logic [2:0]  errs;  // {overflow, underflow, src}
  } vec_t;

  typedef struct {
    logic [2:0]  dst;
    logic [1:0]  src;
    logic [15:0] data;
  } req_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic iv, input logic [2:0] idst,
                     input logic wv, input logic [2:0] wdst, input logic [1:0] src,
                     input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] inp,
                     input logic we, input logic [2:0] wa, input logic [15:0] wd,
                     input logic [7:0] pend, input logic [2:0] errs);
    vec_t v;
    v.rst = rst; v.iv = iv; v.idst = idst; v.wv = wv; v.wdst = wdst; v.src = src;
    v.alu = alu; v.mem = mem; v.inp = inp;
    v.we = we; v.wa = wa; v.wd = wd; v.pend = pend; v.errs = errs;
    tbl.push_back(v);
  endtask

  function automatic logic [30:0] outs();
    return {rf_we, rf_waddr, rf_wdata, pending, err_overflow, err_underflow, err_src};
  endfunction

  task automatic check(input string name, input logic [30:0] act, input logic [30:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got we=%b waddr=%0d wdata=%h pend=%h err=%b, expected we=%b waddr=%0d wdata=%h pend=%h err=%b",
               name, act[30], act[29:27], act[26:11], act[10:3], act[2:0],
               exp[30], exp[29:27], exp[26:11], exp[10:3], exp[2:0]);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [2:0] idst,
                       input logic wv, input logic [2:0] wdst, input logic [1:0] src,
                       input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] inp);
    @(negedge clk);
    reset = rst; issue_valid = iv; issue_dst = idst;
    wb_valid = wv; wb_dst = wdst; wb_src = src;
    alu_result = alu; mem_data = mem; in_data = inp;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model state
  int          mcnt[REG_N];
  req_t        inflight[$];
  logic        m_we;
  logic [2:0]  m_wa;
  logic [15:0] m_wd;
  logic        m_ovf, m_unf, m_src;

  function automatic logic [30:0] model_outs();
    logic [7:0] p;
    p = '0;
    for (int r = 0; r < REG_N; r++) p[r] = (mcnt[r] != 0);
    return {m_we, m_wa, m_wd, p, m_ovf, m_unf, m_src};
  endfunction

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_dst = '0;
    wb_valid = 1'b0; wb_dst = '0; wb_src = '0;
    alu_result = '0; mem_data = '0; in_data = '0;

    // Reset dominates random activity on every input.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom), 2'($urandom),
            16'($urandom), 16'($urandom), 16'($urandom));
      check($sformatf("reset%0d", i), outs(), 31'd0);
    end

    // rst iv idst wv wdst src alu mem in | we wa wd pend errs
    add(0,1,3, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,0,16'h0000,8'h08,3'b000); // issue R3
    add(0,0,0, 1,3,0, 16'h1234,16'h0000,16'h0000, 1,3,16'h1234,8'h08,3'b000); // ALU write
    add(0,0,0, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,3,16'h1234,8'h00,3'b000); // retire R3
    add(0,1,5, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,3,16'h1234,8'h20,3'b000);
    add(0,1,6, 1,5,1, 16'h0000,16'hBEEF,16'h0000, 1,5,16'hBEEF,8'h60,3'b000); // MEM src
    add(0,0,0, 1,6,2, 16'h0000,16'h0000,16'h00FF, 1,6,16'h00FF,8'h40,3'b000); // IN src, back-to-back
    add(0,0,0, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,6,16'h00FF,8'h00,3'b000);
    add(0,1,2, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,6,16'h00FF,8'h04,3'b000);
    add(0,0,0, 1,2,0, 16'h0202,16'h0000,16'h0000, 1,2,16'h0202,8'h04,3'b000);
    add(0,1,2, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2,16'h0202,8'h04,3'b000); // issue+retire R2
    add(0,0,0, 1,2,0, 16'h0A0A,16'h0000,16'h0000, 1,2,16'h0A0A,8'h04,3'b000);
    add(0,0,0, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2,16'h0A0A,8'h00,3'b000);
    add(0,1,7, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2,16'h0A0A,8'h80,3'b000); // R7 cnt 1
    add(0,1,7, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2,16'h0A0A,8'h80,3'b000); // cnt 2
    add(0,1,7, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2,16'h0A0A,8'h80,3'b000); // cnt 3
    add(0,1,7, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,2,16'h0A0A,8'h80,3'b100); // overflow
    add(0,0,0, 1,7,0, 16'h7001,16'h0000,16'h0000, 1,7,16'h7001,8'h80,3'b100);
    add(0,0,0, 1,7,1, 16'h0000,16'h7002,16'h0000, 1,7,16'h7002,8'h80,3'b100); // cnt 2
    add(0,0,0, 1,7,2, 16'h0000,16'h0000,16'h7003, 1,7,16'h7003,8'h80,3'b100); // cnt 1
    add(0,0,0, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,7,16'h7003,8'h00,3'b100); // cnt 0
    add(0,0,0, 1,7,0, 16'h7004,16'h0000,16'h0000, 1,7,16'h7004,8'h00,3'b100);
    add(0,0,0, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,7,16'h7004,8'h00,3'b110); // underflow
    add(0,1,4, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,7,16'h7004,8'h10,3'b110);
    add(0,0,0, 1,4,3, 16'hDEAD,16'h0000,16'h0000, 0,7,16'h7004,8'h10,3'b111); // illegal src
    add(0,0,0, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,7,16'h7004,8'h00,3'b111); // still retires
    add(0,1,1, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,7,16'h7004,8'h02,3'b111);
    add(0,0,0, 1,1,0, 16'h1111,16'h0000,16'h0000, 1,1,16'h1111,8'h02,3'b111);
    add(1,1,1, 1,1,0, 16'h2222,16'h0000,16'h0000, 0,0,16'h0000,8'h00,3'b000); // reset in flight
    add(0,0,0, 0,0,0, 16'h0000,16'h0000,16'h0000, 0,0,16'h0000,8'h00,3'b000); // no stray write

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].idst, tbl[i].wv, tbl[i].wdst, tbl[i].src,
            tbl[i].alu, tbl[i].mem, tbl[i].inp);
      check($sformatf("vec%0d", i), outs(),
            {tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].pend, tbl[i].errs});
    end

    // Randomized traffic against the behavioural model; first cycle resets.
    for (int c = 0; c < 600; c++) begin
      logic        rst, iv, wv, has_ret;
      logic [2:0]  idst, wdst, ret_dst;
      logic [1:0]  src;
      logic [15:0] alu, mem, inp;
      req_t        rq;
      rst  = (c == 0) || ($urandom_range(0, 39) == 0);
      iv   = 1'($urandom);
      idst = 3'($urandom_range(0, 3));
      wv   = 1'($urandom);
      wdst = 3'($urandom_range(0, 3));
      src  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      alu  = 16'($urandom); mem = 16'($urandom); inp = 16'($urandom);

      if (rst) begin
        foreach (mcnt[r]) mcnt[r] = 0;
        inflight.delete();
        m_we = 1'b0; m_wa = '0; m_wd = '0;
        m_ovf = 1'b0; m_unf = 1'b0; m_src = 1'b0;
      end else begin
        has_ret = 1'b0;
        ret_dst = '0;
        if (inflight.size() > 0) begin
          rq      = inflight.pop_front();
          has_ret = 1'b1;
          ret_dst = rq.dst;
        end
        for (int r = 0; r < REG_N; r++) begin
          logic inc, dec;
          inc = iv && (idst == 3'(r));
          dec = has_ret && (ret_dst == 3'(r));
          if (inc && !dec) begin
            if (mcnt[r] == 3) m_ovf = 1'b1;
            else              mcnt[r]++;
          end else if (dec && !inc) begin
            if (mcnt[r] == 0) m_unf = 1'b1;
            else              mcnt[r]--;
          end
        end
        m_we = 1'b0;
        if (wv) begin
          rq.dst  = wdst;
          rq.src  = src;
          rq.data = (src == 2'd0) ? alu : (src == 2'd1) ? mem : inp;
          inflight.push_back(rq);
          if (src == 2'd3) begin
            m_src = 1'b1;
          end else begin
            m_we = 1'b1;
            m_wa = wdst;
            m_wd = rq.data;
          end
        end
      end

      drive(rst, iv, idst, wv, wdst, src, alu, mem, inp);
      check($sformatf("rand%0d", c), outs(), model_outs());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
